// File: rtl/ex_mem_skid_reg_if.sv
// Valid/ready instruction channel between pipeline stages.
// The EX side uses the slave modport, the MEM side the master modport.
interface ex_mem_skid_reg_if #(
  parameter int NBITS  = 32,
  parameter int RBITS  = 5,
  parameter int SZBITS = 5
);
  logic              valid;
  logic              ready;
  logic [NBITS-1:0]  result;
  logic [NBITS-1:0]  rt;
  logic [RBITS-1:0]  rd;
  logic              memtoreg;
  logic              memread;
  logic              memwrite;
  logic              regwrite;
  logic [SZBITS-1:0] sizecontrol;

  modport master (
    output valid, result, rt, rd, memtoreg, memread, memwrite, regwrite, sizecontrol,
    input  ready
  );

  modport slave (
    input  valid, result, rt, rd, memtoreg, memread, memwrite, regwrite, sizecontrol,
    output ready
  );
endinterface

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM stage register with a 2-entry skid buffer, flush and a saturating stall counter.
//   state | meaning
//   EMPTY | nothing held, MEM sees a bubble
//   ONE   | main entry valid and driving MEM
//   FULL  | main and skid valid, EX is back-pressured
module ex_mem_skid_reg #(
  parameter int NBITS   = 32,
  parameter int RBITS   = 5,
  parameter int SZBITS  = 5,
  parameter int CNTBITS = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_flush,
  input  logic                i_clr_cnt,
  ex_mem_skid_reg_if.slave    ex,
  ex_mem_skid_reg_if.master   mem,
  output logic [CNTBITS-1:0]  o_stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // ctrl = {memtoreg, memread, memwrite, regwrite}
  typedef struct packed {
    logic [NBITS-1:0]  result;
    logic [NBITS-1:0]  rt;
    logic [RBITS-1:0]  rd;
    logic [SZBITS-1:0] sizecontrol;
    logic [3:0]        ctrl;
  } entry_t;

  state_t               state_q, state_d;
  entry_t               main_q, main_d;
  entry_t               skid_q, skid_d;
  logic [CNTBITS-1:0]   cnt_q, cnt_d;

  entry_t ex_entry;
  logic   ex_ready;
  logic   mem_valid;
  logic   accept;
  logic   consume;

  // Handshake outputs are decoded from state only, so EX_ready has no path from MEM_ready.
  assign ex_ready  = (state_q != FULL);
  assign mem_valid = (state_q != EMPTY);
  assign accept    = ex.valid & ex_ready;
  assign consume   = mem_valid & mem.ready;

  always_comb begin
    ex_entry             = '0;
    ex_entry.result      = ex.result;
    ex_entry.rt          = ex.rt;
    ex_entry.rd          = ex.rd;
    ex_entry.sizecontrol = ex.sizecontrol;
    ex_entry.ctrl        = {ex.memtoreg, ex.memread, ex.memwrite, ex.regwrite};
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = ex_entry;
        end
      end
      ONE: begin
        if (accept && !consume) begin
          state_d = FULL;
          skid_d  = ex_entry;
        end else if (accept && consume) begin
          main_d  = ex_entry;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (consume) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    // Flush drops everything, including a same-cycle accept; data fields keep their value.
    if (i_flush) begin
      state_d     = EMPTY;
      main_d      = main_q;
      skid_d      = skid_q;
      main_d.ctrl = '0;
      skid_d.ctrl = '0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr_cnt) begin
      cnt_d = '0;
    end else if (mem_valid && !mem.ready && (cnt_q != {CNTBITS{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex.ready        = ex_ready;
  assign mem.valid       = mem_valid;
  assign mem.result      = main_q.result;
  assign mem.rt          = main_q.rt;
  assign mem.rd          = main_q.rd;
  assign mem.sizecontrol = main_q.sizecontrol;
  // Control bits are gated so a bubble can never write memory or the register file.
  assign mem.memtoreg    = main_q.ctrl[3] & mem_valid;
  assign mem.memread     = main_q.ctrl[2] & mem_valid;
  assign mem.memwrite    = main_q.ctrl[1] & mem_valid;
  assign mem.regwrite    = main_q.ctrl[0] & mem_valid;
  assign o_stall_cnt     = cnt_q;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Bench for ex_mem_skid_reg: directed scenarios plus random traffic against a queue model.
module tb_ex_mem_skid_reg;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] rt;
    logic [4:0]  rd;
    logic [4:0]  sz;
    logic [3:0]  ctrl;
  } pl_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_clr_cnt = 1'b0;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt_small;

  ex_mem_skid_reg_if #(.NBITS(32), .RBITS(5), .SZBITS(5)) ex ();
  ex_mem_skid_reg_if #(.NBITS(32), .RBITS(5), .SZBITS(5)) mem ();
  ex_mem_skid_reg_if #(.NBITS(32), .RBITS(5), .SZBITS(5)) ex2 ();
  ex_mem_skid_reg_if #(.NBITS(32), .RBITS(5), .SZBITS(5)) mem2 ();

  ex_mem_skid_reg #(.NBITS(32), .RBITS(5), .SZBITS(5), .CNTBITS(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_clr_cnt(i_clr_cnt),
    .ex(ex), .mem(mem), .o_stall_cnt(stall_cnt)
  );

  // Narrow-counter copy sees identical traffic; only its counter is of interest.
  ex_mem_skid_reg #(.NBITS(32), .RBITS(5), .SZBITS(5), .CNTBITS(2)) dut_small (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_clr_cnt(i_clr_cnt),
    .ex(ex2), .mem(mem2), .o_stall_cnt(stall_cnt_small)
  );

  assign ex2.valid       = ex.valid;
  assign ex2.result      = ex.result;
  assign ex2.rt          = ex.rt;
  assign ex2.rd          = ex.rd;
  assign ex2.sizecontrol = ex.sizecontrol;
  assign ex2.memtoreg    = ex.memtoreg;
  assign ex2.memread     = ex.memread;
  assign ex2.memwrite    = ex.memwrite;
  assign ex2.regwrite    = ex.regwrite;
  assign mem2.ready      = mem.ready;

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fails  = 0;

  pl_t mq[$];
  pl_t last_shown;
  int  cnt_model;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic pl_t mk(input logic [31:0] res, input logic [31:0] rt,
                             input logic [4:0] rd, input logic [4:0] sz, input logic [3:0] ctrl);
    pl_t p;
    p.result = res; p.rt = rt; p.rd = rd; p.sz = sz; p.ctrl = ctrl;
    return p;
  endfunction

  function automatic pl_t rand_pl();
    return mk($urandom, $urandom, 5'($urandom), 5'($urandom), 4'($urandom));
  endfunction

  task automatic model_reset();
    mq.delete();
    last_shown = '0;
    cnt_model  = 0;
  endtask

  task automatic model_step(input logic v, input pl_t p, input logic r, input logic f, input logic c);
    bit acc, con;
    acc = v && (mq.size() < 2);
    con = (mq.size() > 0) && r;
    if (c) cnt_model = 0;
    else if ((mq.size() > 0) && !r && cnt_model < 65535) cnt_model++;
    if (f) begin
      mq.delete();
    end else begin
      if (con) void'(mq.pop_front());
      if (acc) mq.push_back(p);
    end
    if (mq.size() > 0) last_shown = mq[0];
  endtask

  task automatic check_all();
    logic [3:0] exp_ctrl;
    exp_ctrl = (mq.size() > 0) ? last_shown.ctrl : 4'b0000;
    check_eq("ex_ready",  64'(ex.ready),        64'(mq.size() < 2));
    check_eq("mem_valid", 64'(mem.valid),       64'(mq.size() > 0));
    check_eq("result",    64'(mem.result),      64'(last_shown.result));
    check_eq("rt",        64'(mem.rt),          64'(last_shown.rt));
    check_eq("rd",        64'(mem.rd),          64'(last_shown.rd));
    check_eq("sizectl",   64'(mem.sizecontrol), 64'(last_shown.sz));
    check_eq("ctrl",      64'({mem.memtoreg, mem.memread, mem.memwrite, mem.regwrite}), 64'(exp_ctrl));
    check_eq("stall_cnt", 64'(stall_cnt),       64'(cnt_model));
    check_eq("stall_cnt_sat", 64'(stall_cnt_small), 64'((cnt_model > 3) ? 3 : cnt_model));
  endtask

  // Called at a negedge; drives one cycle of inputs, then checks after the next posedge.
  task automatic drive(input logic v, input pl_t p, input logic r, input logic f, input logic c);
    ex.valid       = v;
    ex.result      = p.result;
    ex.rt          = p.rt;
    ex.rd          = p.rd;
    ex.sizecontrol = p.sz;
    {ex.memtoreg, ex.memread, ex.memwrite, ex.regwrite} = p.ctrl;
    mem.ready = r;
    i_flush   = f;
    i_clr_cnt = c;
    @(posedge i_clk);
    model_step(v, p, r, f, c);
    @(negedge i_clk);
    check_all();
  endtask

  task automatic idle(input logic r);
    drive(1'b0, rand_pl(), r, 1'b0, 1'b0);
  endtask

  initial begin
    ex.valid = 1'b0; ex.result = '0; ex.rt = '0; ex.rd = '0; ex.sizecontrol = '0;
    ex.memtoreg = 1'b0; ex.memread = 1'b0; ex.memwrite = 1'b0; ex.regwrite = 1'b0;
    mem.ready = 1'b0;
    model_reset();
    repeat (2) @(negedge i_clk);
    check_all();
    i_rst = 1'b1;

    // pass-through
    drive(1'b1, mk(8, 9, 7, 4, 4'b1111), 1'b1, 1'b0, 1'b0);
    check_eq("pt_valid",  64'(mem.valid), 64'd1);
    check_eq("pt_result", 64'(mem.result), 64'd8);
    check_eq("pt_ctrl",   64'({mem.memtoreg, mem.memread, mem.memwrite, mem.regwrite}), 64'hf);
    idle(1'b1);
    check_eq("pt_bubble_ctrl", 64'({mem.memtoreg, mem.memread, mem.memwrite, mem.regwrite}), 64'h0);

    // back-pressure
    drive(1'b1, mk(5, 50, 1, 1, 4'b0010), 1'b0, 1'b0, 1'b0);
    drive(1'b1, mk(6, 60, 2, 2, 4'b0001), 1'b0, 1'b0, 1'b0);
    check_eq("bp_ex_ready", 64'(ex.ready), 64'd0);
    check_eq("bp_hold",     64'(mem.result), 64'd5);
    idle(1'b1);
    check_eq("bp_second", 64'(mem.result), 64'd6);
    idle(1'b1);
    check_eq("bp_empty", 64'(ex.ready), 64'd1);

    // streaming, clear counter first so the zero check is meaningful
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, mk(32'(k), 32'(k * 3), 5'(k), 5'(k), 4'b1000), 1'b1, 1'b0, 1'b0);
      check_eq("stream_result", 64'(mem.result), 64'(k));
      check_eq("stream_ready",  64'(ex.ready), 64'd1);
    end
    check_eq("stream_cnt", 64'(stall_cnt), 64'd0);
    idle(1'b1);

    // flush while FULL with an incoming instruction
    drive(1'b1, mk(21, 0, 3, 0, 4'b0010), 1'b0, 1'b0, 1'b0);
    drive(1'b1, mk(22, 0, 4, 0, 4'b0010), 1'b0, 1'b0, 1'b0);
    drive(1'b1, mk(23, 0, 5, 0, 4'b0010), 1'b1, 1'b1, 1'b0);
    check_eq("fl_valid",    64'(mem.valid), 64'd0);
    check_eq("fl_ready",    64'(ex.ready), 64'd1);
    check_eq("fl_memwrite", 64'(mem.memwrite), 64'd0);
    repeat (3) idle(1'b1);

    // stall counter and saturation
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, rand_pl(), 1'b0, 1'b0, 1'b0);
    repeat (7) idle(1'b0);
    check_eq("cnt_seven", 64'(stall_cnt), 64'd7);
    check_eq("cnt_sat",   64'(stall_cnt_small), 64'd3);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check_eq("cnt_clr", 64'(stall_cnt), 64'd0);
    idle(1'b1);

    // asynchronous reset while FULL
    drive(1'b1, rand_pl(), 1'b0, 1'b0, 1'b0);
    drive(1'b1, mk(32'hdead, 1, 1, 1, 4'b1111), 1'b0, 1'b0, 1'b0);
    ex.valid = 1'b0;
    #2;
    i_rst = 1'b0;
    #1;
    model_reset();
    check_eq("ar_valid",  64'(mem.valid), 64'd0);
    check_eq("ar_ready",  64'(ex.ready), 64'd1);
    check_eq("ar_result", 64'(mem.result), 64'd0);
    check_eq("ar_ctrl",   64'({mem.memtoreg, mem.memread, mem.memwrite, mem.regwrite}), 64'h0);
    check_eq("ar_cnt",    64'(stall_cnt), 64'd0);
    @(negedge i_clk);
    check_all();
    i_rst = 1'b1;
    drive(1'b1, mk(8, 9, 7, 4, 4'b1111), 1'b1, 1'b0, 1'b0);
    check_eq("ar_pt_result", 64'(mem.result), 64'd8);
    idle(1'b1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) != 0), rand_pl(), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 24) == 0), ($urandom_range(0, 40) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid_reg.md
Name: ex_mem_skid_reg

Overview:
Next-generation EX/MEM pipeline register for the MIPS pipeline. It replaces the plain always-load stage register with a valid/ready handshake stage that has a 2-entry skid buffer, so the MEM stage can back-pressure EX without losing an instruction. It adds a synchronous flush for bubble insertion and a saturating back-pressure cycle counter for debug. It sits between the EX stage (ALU result, store data, destination register, control bits) and the MEM stage (data memory access).

Parameters:
NBITS, 32, width of result and Rt data.
RBITS, 5, width of destination register index.
SZBITS, 5, width of memory size-control field.
CNTBITS, 16, width of the stall counter.

Ports:
i_clk  in  1  clock, rising edge.
i_rst  in  1  asynchronous, active-low reset.
i_flush  in  1  synchronous flush; empties the stage.
i_clr_cnt  in  1  synchronous clear of o_stall_cnt.
EX_valid  in  1  EX presents a valid instruction.
EX_ready  out  1  stage can accept an instruction this cycle.
EX_result  in  NBITS  ALU result / memory address.
EX_Rt  in  NBITS  store data.
EX_rd  in  RBITS  destination register index.
EX_memtoreg, EX_memread, EX_memwrite, EX_regwrite  in  1 each  control bits.
EX_sizecontrol  in  SZBITS  memory access size/sign control.
MEM_valid  out  1  output holds a valid instruction.
MEM_ready  in  1  MEM stage consumes the output this cycle.
MEM_result, MEM_Rt, MEM_rd, MEM_memtoreg, MEM_memread, MEM_memwrite, MEM_regwrite, MEM_sizecontrol  out  widths as EX_*  registered instruction fields.
o_stall_cnt  out  CNTBITS  cycles with MEM_valid=1 and MEM_ready=0.

Behaviour:
- Storage: main register (drives MEM_*) and skid register, each with a full field set.
- State: EMPTY (nothing held), ONE (main valid), FULL (main and skid valid).
- accept = EX_valid & EX_ready. consume = MEM_valid & MEM_ready.
- EX_ready = 1 in EMPTY and ONE, 0 in FULL. It is decoded from state, so it does not depend combinationally on MEM_ready.
- MEM_valid = 1 in ONE and FULL.
- Transitions and data moves on the rising edge:
  - EMPTY: accept -> ONE, main <= EX. Otherwise stay.
  - ONE: accept & !consume -> FULL, skid <= EX. accept & consume -> ONE, main <= EX. !accept & consume -> EMPTY. Neither -> hold.
  - FULL: consume -> ONE, main <= skid. Otherwise hold. No accept is possible in FULL.
- Latency: an instruction accepted in cycle N is on MEM_* with MEM_valid=1 in cycle N+1 when the stage was EMPTY or consumed in cycle N. Ordering is strictly FIFO.
- MEM_* fields stay stable while MEM_valid=1 and MEM_ready=0.
- Bubble safety: MEM_memtoreg, MEM_memread, MEM_memwrite and MEM_regwrite are forced to 0 whenever MEM_valid=0. MEM_result, MEM_Rt, MEM_rd and MEM_sizecontrol keep their last value.
- Flush (i_flush=1): highest priority after reset.
  - Next state is EMPTY and both entries are invalidated.
  - A simultaneous accept is discarded, and a simultaneous consume still counts as consumed by MEM.
  - Stored control bits in both registers are cleared to 0.
- Stall counter:
  - Increments by 1 each cycle MEM_valid=1 and MEM_ready=0.
  - Saturates at 2^CNTBITS-1 with no wrap.
  - i_clr_cnt=1 sets it to 0, taking priority over increment.
  - Flush does not clear it.
- Reset (i_rst=0, asynchronous, any time including mid-transfer):
  - State EMPTY, EX_ready=1, MEM_valid=0.
  - All MEM_* outputs 0, skid register 0, o_stall_cnt=0.
  - The stage operates normally from the first rising edge after i_rst returns to 1.

Test Plan:
- Reset then pass-through with MEM_ready=1: EX_result=8, Rt=9, rd=7, all control bits=1, sizecontrol=4, EX_valid=1 for one cycle -> next cycle MEM_valid=1 with identical fields. The cycle after that, MEM_valid=0 and all control outputs are 0.
- Back-pressure: MEM_ready=0, send A(result=5) then B(result=6) -> EX_ready drops to 0 after B and MEM_result holds 5. Raise MEM_ready -> MEM_result shows 5, then 6, in order. The stage then returns to EMPTY and EX_ready=1.
- Continuous streaming: MEM_ready=1 and EX_valid=1 for 10 cycles with result 1..10 -> MEM_result 1..10 on consecutive cycles, EX_ready constantly 1, o_stall_cnt=0.
- Flush while FULL with a simultaneous EX_valid=1 -> next cycle MEM_valid=0, EX_ready=1, MEM_memwrite=0. The flushed entries and the incoming instruction never appear on MEM.
- Stall counter: hold MEM_ready=0 with a valid entry for 7 cycles -> o_stall_cnt=7. Pulse i_clr_cnt -> 0. With CNTBITS=2 and a 6-cycle stall -> o_stall_cnt saturates at 3.
- Asynchronous reset asserted between clock edges while FULL -> outputs go to 0 immediately without waiting for an edge. After release, the first accept behaves as in the pass-through test.
